somador_datapath: RTL and testbench
===================================

Name: somador_datapath

Overview:
- Datapath stage directly downstream of the somador control FSM.
- Consumes the FSM's address/rden/wren/load/transf/clear/ready controls.
- Holds the 32-word operand/result memory, a registered read port, the accumulator and the transfer (result) register.
- Provides a host preload port, used only while the FSM reports ready, and protocol-error and overflow status flags.

Parameters:
- DATA_W, 8: memory word width.
- ADDR_W, 5: memory address width (2^ADDR_W words).
- ACC_W, 13: accumulator/result width (DATA_W+ADDR_W, so a full sum cannot overflow at defaults).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  FSM memory address.
- rden  in  1  FSM read enable.
- wren  in  1  FSM write enable.
- load  in  1  accumulate mem_q into acc.
- transf  in  1  copy acc into res.
- clear  in  1  zero acc/ovf/load_cnt.
- ready  in  1  FSM idle; host port permitted.
- host_we  in  1  host preload write strobe.
- host_addr  in  ADDR_W  host preload address.
- host_wdata  in  DATA_W  host preload data.
- mem_q  out  DATA_W  registered read data.
- acc  out  ACC_W  accumulator.
- res  out  ACC_W  transfer register.
- load_cnt  out  ADDR_W+1  loads since clear, saturating.
- ovf  out  1  sticky accumulator carry-out.
- err  out  1  sticky protocol error.
- host_rej  out  1  one-cycle pulse, host write refused.

Behaviour:
- Reset (reset=0, async): mem_q, acc, res, load_cnt, ovf, err, host_rej all 0. Memory contents are not reset. Deassertion takes effect at the next rising clk.
- Reset mid-operation: all registers clear immediately. Any in-flight read or write is lost; a write on the same edge as reset assertion does not occur.
- Read: rden=1 at edge gives mem_q <= mem[address], one-cycle latency. rden=0 holds mem_q.
- Read/write collision: rden and wren on the same address, same edge, is read-before-write; mem_q gets the old word.
- Load: load=1 gives acc <= acc + zero-extend(mem_q), modulo 2^ACC_W.
  - Carry-out sets ovf.
  - load_cnt increments, saturating at 2^ADDR_W.
- Clear: clear=1 gives acc=0, ovf=0, load_cnt=0. Clear has priority over load. err is NOT cleared by clear; only reset clears it.
- Transfer: transf=1 gives res <= acc (pre-update value if load is also asserted).
- Write: wren=1 gives mem[address] <= res[DATA_W-1:0], using the res value before this edge.
- Protocol errors (err set, sticky):
  - load=1 and transf=1 on the same edge: acc and res both hold.
  - wren=1 and transf=1 on the same edge: the write still occurs with old res.
- Host port:
  - Accepted only when host_we=1, ready=1 and wren=0; gives mem[host_addr] <= host_wdata.
  - host_we=1 with ready=0 or wren=1: no write; host_rej=1 for the next cycle only.
  - A single write port is shared; the FSM write always wins.
- Address wrap: address is ADDR_W bits; no out-of-range case exists.

Optional Feature:
- Macro: SOMADOR_SAT_WRITE_EN.
- Defined: a write stores {DATA_W{1'b1}} when res[ACC_W-1:DATA_W] != 0, else res[DATA_W-1:0].
- Undefined: plain truncation to res[DATA_W-1:0].
- err/ovf behaviour is identical either way.

Decomposition:
- Package somador_pkg holds DATA_W, ADDR_W and ACC_W defaults, plus the ERR_LOAD_TRANSF and ERR_WREN_TRANSF cause encodings for bench messages.
- One sub-module, somador_ram: single write port, registered read, read-before-write, no reset on the array.
- Accumulator, result, flags and host arbitration stay in the top module.

Test Plan:
- Assert reset mid-accumulation with acc=37 -> all outputs 0 immediately; memory word 3 still reads its preloaded value after release.
- Host preload mem[i]=i+1 (i=0..31) with ready=1 -> FSM-style sequence rden/load/transf/wren address 0 -> res=528 (0x210), mem[0]=0x10 truncated (0xFF with SOMADOR_SAT_WRITE_EN), ovf=0, load_cnt=32.
- Preload all words 0xFF, ACC_W overridden to 8 -> ovf=1 after the second load; clear -> acc=0, ovf=0, err unchanged.
- load=1 and transf=1 same edge with acc=5, res=2 -> acc=5, res=2 held, err=1 sticky through clear.
- rden and wren to address 7 same edge, mem[7]=0x11, res=0x22 -> mem_q=0x11; next read of address 7 returns 0x22.
- host_we=1 with ready=0, then host_we=1 with ready=1 and wren=1 -> host_rej pulses one cycle each time; host data is not written.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared widths and error-cause encodings for the somador datapath.
// Optional write saturation is selected with SOMADOR_SAT_WRITE_EN.
package somador_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int ACC_W  = DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_LOAD_TRANSF = 2'd1,
        ERR_WREN_TRANSF = 2'd2
    } err_cause_e;
endpackage

// File: rtl/somador_ram.sv
// Operand/result memory: one write port, registered read, read-before-write.
// The array itself is never reset; only the read register is.
module somador_ram #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem_r [2**AW];
    logic [DW-1:0] q_d;
    logic [DW-1:0] q_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    always_comb begin
        q_d = q_q;
        if (re) begin
            q_d = mem_r[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/somador_datapath.sv
// Somador datapath: memory, accumulator, result register, status flags.
// Define SOMADOR_SAT_WRITE_EN to saturate result write-back to memory.
module somador_datapath
    import somador_pkg::*;
#(
    parameter int DATA_W = somador_pkg::DATA_W,
    parameter int ADDR_W = somador_pkg::ADDR_W,
    parameter int ACC_W  = somador_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              rden,
    input  logic              wren,
    input  logic              load,
    input  logic              transf,
    input  logic              clear,
    input  logic              ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] mem_q,
    output logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  res,
    output logic [ADDR_W:0]   load_cnt,
    output logic              ovf,
    output logic              err,
    output logic              host_rej
);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [ACC_W-1:0]  acc_d, acc_q;
    logic [ACC_W-1:0]  res_d, res_q;
    logic [ADDR_W:0]   cnt_d, cnt_q;
    logic              ovf_d, ovf_q;
    logic              err_d, err_q;
    logic              rej_d, rej_q;
    logic [ACC_W:0]    sum;
    logic              host_ok;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] fsm_wdata;

    always_comb begin
`ifdef SOMADOR_SAT_WRITE_EN
        fsm_wdata = (|res_q[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                              : res_q[DATA_W-1:0];
`else
        fsm_wdata = res_q[DATA_W-1:0];
`endif
    end

    always_comb begin
        acc_d = acc_q;
        res_d = res_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        sum   = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, mem_q};
        err_d = err_q | (load & transf) | (wren & transf);
        if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (load && !transf) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Transfer sees the accumulator before this edge's load.
        if (transf && !load) begin
            res_d = acc_q;
        end
    end

    always_comb begin
        host_ok   = host_we & ready & ~wren;
        rej_d     = host_we & ~host_ok;
        ram_we    = (wren | host_ok) & reset;
        ram_waddr = wren ? address : host_addr;
        ram_wdata = wren ? fsm_wdata : host_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            rej_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            rej_q <= rej_d;
        end
    end

    somador_ram #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rden),
        .raddr (address),
        .q     (mem_q)
    );

    assign acc      = acc_q;
    assign res      = res_q;
    assign load_cnt = cnt_q;
    assign ovf      = ovf_q;
    assign err      = err_q;
    assign host_rej = rej_q;
endmodule

// File: tb/tb_somador_datapath.sv
// Scoreboard bench for somador_datapath against an arithmetic reference model.
// Honours SOMADOR_SAT_WRITE_EN for the expected write-back value.
module tb_somador_datapath;
    import somador_pkg::*;

    localparam int NW   = 1 << ADDR_W;
    localparam int AMOD = 1 << ACC_W;
    localparam int DMAX = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              rden, wren, load, transf, clear, ready, host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] mem_q;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  res;
    logic [ADDR_W:0]   load_cnt;
    logic              ovf, err, host_rej;

    somador_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .rden       (rden),
        .wren       (wren),
        .load       (load),
        .transf     (transf),
        .clear      (clear),
        .ready      (ready),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .mem_q      (mem_q),
        .acc        (acc),
        .res        (res),
        .load_cnt   (load_cnt),
        .ovf        (ovf),
        .err        (err),
        .host_rej   (host_rej)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    mq, acc, res, cnt, ovf, err, rej;
    } exp_t;

    exp_t sb[$];
    int   m_mem[NW];
    int   m_acc, m_res, m_mq, m_cnt, m_ovf, m_err, m_rej;
    int   checks = 0;
    int   failures = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic int wval(int r);
`ifdef SOMADOR_SAT_WRITE_EN
        return (r > DMAX) ? DMAX : r;
`else
        return r % (DMAX + 1);
`endif
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_res = 0; m_mq = 0; m_cnt = 0;
        m_ovf = 0; m_err = 0; m_rej = 0;
    endfunction

    task automatic step(string tag, bit rd, bit wr, bit ld, bit tf, bit cl,
                        bit rdy, bit hwe, int a, int ha, int hd);
        int   old_acc, old_res, old_mq, s;
        exp_t e;
        rden = rd; wren = wr; load = ld; transf = tf; clear = cl;
        ready = rdy; host_we = hwe;
        address = ADDR_W'(a); host_addr = ADDR_W'(ha);
        host_wdata = DATA_W'(hd);
        @(posedge clk);
        old_acc = m_acc; old_res = m_res; old_mq = m_mq;
        if (rd) m_mq = m_mem[a];
        if ((ld && tf) || (wr && tf)) m_err = 1;
        if (cl) begin
            m_acc = 0; m_ovf = 0; m_cnt = 0;
        end else if (ld && !tf) begin
            s = old_acc + old_mq;
            if (s >= AMOD) m_ovf = 1;
            m_acc = s % AMOD;
            m_cnt = (m_cnt < NW) ? m_cnt + 1 : NW;
        end
        if (tf && !ld) m_res = old_acc;
        if (wr) m_mem[a] = wval(old_res);
        else if (hwe && rdy) m_mem[ha] = hd;
        m_rej = (hwe && (!rdy || wr)) ? 1 : 0;
        e.tag = tag; e.mq = m_mq; e.acc = m_acc; e.res = m_res;
        e.cnt = m_cnt; e.ovf = m_ovf; e.err = m_err; e.rej = m_rej;
        sb.push_back(e);
        #1;
    endtask

    task automatic host_wr(int a, int d);
        step("host", 0, 0, 0, 0, 0, 1, 1, 0, a, d);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, ".mem_q"}, int'(mem_q), 0);
        chk({nm, ".acc"}, int'(acc), 0);
        chk({nm, ".res"}, int'(res), 0);
        chk({nm, ".cnt"}, int'(load_cnt), 0);
        chk({nm, ".ovf"}, int'(ovf), 0);
        chk({nm, ".err"}, int'(err), 0);
        chk({nm, ".rej"}, int'(host_rej), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".mem_q"}, int'(mem_q), e.mq);
                chk({e.tag, ".acc"}, int'(acc), e.acc);
                chk({e.tag, ".res"}, int'(res), e.res);
                chk({e.tag, ".cnt"}, int'(load_cnt), e.cnt);
                chk({e.tag, ".ovf"}, int'(ovf), e.ovf);
                chk({e.tag, ".err"}, int'(err), e.err);
                chk({e.tag, ".rej"}, int'(host_rej), e.rej);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        reset = 1'b0;
        rden = 0; wren = 0; load = 0; transf = 0; clear = 0;
        ready = 0; host_we = 0; address = '0; host_addr = '0;
        host_wdata = '0;
        for (int i = 0; i < NW; i++) m_mem[i] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_zero("por");
        reset = 1'b1;

        for (int i = 0; i < NW; i++) host_wr(i, i + 1);

        step("clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < NW; k++)
            step("sum", 1, 0, k > 0, 0, 0, 0, 0, k, 0, 0);
        step("sum", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("xfer", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("sum_res", int'(res), 528);
        chk("sum_cnt", int'(load_cnt), NW);
        step("wb", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rd0", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef SOMADOR_SAT_WRITE_EN
        chk("wb_mem0", int'(mem_q), 255);
`else
        chk("wb_mem0", int'(mem_q), 16);
`endif

        step("rej1", 0, 0, 0, 0, 0, 0, 1, 0, 9, 8'hAA);
        step("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("rej2", 0, 1, 0, 0, 0, 1, 1, 20, 10, 8'hBB);
        step("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("rd9", 1, 0, 0, 0, 0, 1, 0, 9, 0, 0);
        step("rd10", 1, 0, 0, 0, 0, 1, 0, 10, 0, 0);

        host_wr(7, 8'h11);
        host_wr(1, 8'h22);
        step("clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("r22", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("r22", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("r22", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("coll", 1, 1, 0, 0, 0, 0, 0, 7, 0, 0);
        step("coll2", 1, 0, 0, 0, 0, 0, 0, 7, 0, 0);
        chk("coll_new", int'(mem_q), 8'h22);

        host_wr(1, 2);
        step("clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("e", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("e", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("e", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        host_wr(1, 3);
        step("e", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("e", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("ldtf", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("ldtf_acc", int'(acc), 5);
        chk("ldtf_res", int'(res), 2);
        step("eclr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("err_sticky", int'(err), 1);

        host_wr(4, DMAX);
        step("clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("ov", 1, 0, 0, 0, 0, 0, 0, 4, 0, 0);
        for (int k = 0; k < 34; k++)
            step("ov", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("ovclr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int k = 0; k < 400; k++)
            step("rnd", 1'($urandom % 2), $urandom % 4 == 0,
                 1'($urandom % 2), $urandom % 5 == 0, $urandom % 8 == 0,
                 1'($urandom % 2), $urandom % 3 == 0,
                 int'($urandom % NW), int'($urandom % NW),
                 int'($urandom % (DMAX + 1)));

        host_wr(3, 37);
        step("clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("a37", 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        step("a37", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_acc", int'(acc), 37);
        @(negedge clk);
        #2;
        rden = 0; wren = 0; load = 0; transf = 0; clear = 0;
        ready = 0; host_we = 0;
        reset = 1'b0;
        #1;
        chk_zero("mid_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        step("rd3", 1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        chk("rd3_kept", int'(mem_q), 37);

        @(negedge clk);
        #1;
        chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
